cpu_mc: RTL and testbench

- Parametrised multi-cycle accumulator processor; successor to the single-cycle 8-bit teaching core.
- Generalised in word width, number of memory-mapped output ports and execution mode.
- Adds fetch/decode/execute sequencing, HALT, and a single-step debug mode.
- Sits at board top level. Instruction memory is external (synchronous ROM); data RAM and I/O registers are internal. Output ports feed seven-segment drivers.

---
 rtl/cpu_mc.sv | 166 ++++++++++++++++
 tb/tb_cpu_mc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc.sv
// Multi-cycle accumulator processor: FETCH/DECODE/EXEC sequencing over an external
// synchronous instruction ROM, with internal data RAM, memory-mapped output ports and single-step.
module cpu_mc #(
  parameter int WORD_W  = 8,
  parameter int OP_W    = 3,
  parameter int NUM_OUT = 2
) (
  input  logic                      clock,
  input  logic                      n_reset,
  input  logic [WORD_W-1:0]         switches,
  output logic [WORD_W-OP_W-1:0]    imem_addr,
  input  logic [WORD_W-1:0]         imem_rdata,
  input  logic                      step_mode,
  input  logic                      step,
  output logic [NUM_OUT*WORD_W-1:0] out_data,
  output logic                      halted,
  output logic [WORD_W-OP_W-1:0]    pc_out
);

  localparam int A         = WORD_W - OP_W;
  localparam int RAM_DEPTH = (1 << A) - 1 - NUM_OUT;

  localparam logic [A-1:0] SW_ADDR = {A{1'b1}};
  localparam logic [A-1:0] RAM_TOP = A'(RAM_DEPTH);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_LOADI = 3'd4,
    OP_BNE   = 3'd5,
    OP_BR    = 3'd6,
    OP_HALT  = 3'd7
  } op_t;

  state_t state, state_next;

  logic [A-1:0]      pc;
  logic [WORD_W-1:0] acc;
  logic              z;
  logic [WORD_W-1:0] ir;
  logic [WORD_W-1:0] out_reg [NUM_OUT];
  logic [WORD_W-1:0] ram     [RAM_DEPTH];

  logic [OP_W-1:0]   opcode;
  logic [A-1:0]      operand;
  op_t               op;
  logic              op_nop;

  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] acc_next;
  logic              acc_we;
  logic              br_taken;
  logic              store_en;

  assign opcode  = ir[WORD_W-1 -: OP_W];
  assign operand = ir[A-1:0];
  assign op      = op_t'(opcode[2:0]);
  // Wider opcode fields reserve their upper encodings; those execute as NOP.
  assign op_nop  = (opcode >> 3) != '0;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (!n_reset) state <= FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FETCH:   if (!(step_mode && !step)) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = (!op_nop && op == OP_HALT) ? HALTED : FETCH;
      HALTED:  state_next = HALTED;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    halted    = (state == HALTED);
    imem_addr = pc;
    pc_out    = pc;
  end

  // ---------------------------------------------------------------- operand read
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    mem_rdata = '0;
    if (operand == SW_ADDR) begin
      mem_rdata = switches;
    end else if (operand < RAM_TOP) begin
      mem_rdata = ram[operand];
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (operand == SW_ADDR - A'(k + 1)) mem_rdata = out_reg[k];
      end
    end
  end

  // ---------------------------------------------------------------- execute
  always_comb begin
    acc_we   = 1'b0;
    acc_next = acc;
    br_taken = 1'b0;
    store_en = 1'b0;
    if (state == EXEC && !op_nop) begin
      case (op)
        OP_LOAD:  begin acc_we = 1'b1; acc_next = mem_rdata;       end
        OP_STORE: store_en = 1'b1;
        OP_ADD:   begin acc_we = 1'b1; acc_next = acc + mem_rdata; end
        OP_SUB:   begin acc_we = 1'b1; acc_next = acc - mem_rdata; end
        OP_LOADI: begin acc_we = 1'b1; acc_next = {{OP_W{1'b0}}, operand}; end
        OP_BNE:   br_taken = !z;
        OP_BR:    br_taken = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      pc  <= '0;
      acc <= '0;
      z   <= 1'b1;
      ir  <= '0;
      for (int k = 0; k < NUM_OUT; k++) out_reg[k] <= '0;
    end else begin
      if (state == DECODE) begin
        ir <= imem_rdata;
        pc <= pc + 1'b1;
      end
      if (br_taken) pc <= operand;
      if (acc_we) begin
        acc <= acc_next;
        z   <= (acc_next == '0);
      end
      if (store_en) begin
        for (int k = 0; k < NUM_OUT; k++) begin
          if (operand == SW_ADDR - A'(k + 1)) out_reg[k] <= acc;
        end
      end
    end
  end

  // NOTE: the RAM array has no reset; only the write is gated so a store
  // in flight during reset never commits, while contents survive reset.
  always_ff @(posedge clock) begin
    if (n_reset && store_en && operand < RAM_TOP) ram[operand] <= acc;
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_data[k*WORD_W +: WORD_W] = out_reg[k];
  end

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: small programs in a synchronous ROM model with
// hand-computed results, cycle counts, step mode and reset behaviour.
module tb_cpu_mc;

  logic        clock = 1'b0;
  logic        n_reset = 1'b0;
  logic [7:0]  switches = 8'h03;
  logic [4:0]  imem_addr;
  logic [7:0]  imem_rdata = 8'h00;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [15:0] out_data;
  logic        halted;
  logic [4:0]  pc_out;

  int checks = 0;
  int failures = 0;

  logic [7:0] rom [32];

  cpu_mc #(.WORD_W(8), .OP_W(3), .NUM_OUT(2)) dut (
    .clock      (clock),
    .n_reset    (n_reset),
    .switches   (switches),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .step_mode  (step_mode),
    .step       (step),
    .out_data   (out_data),
    .halted     (halted),
    .pc_out     (pc_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) imem_rdata <= rom[imem_addr];

  function automatic logic [7:0] enc(input logic [2:0] op, input logic [4:0] arg);
    return {op, arg};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = enc(3'd7, 5'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    n_reset = 1'b0;
    cycles(2);
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_rom();
    step_mode = 1'b0;
    reset_dut();
    checks++; if (pc_out !== 5'd0) begin failures++; $display("FAIL reset_pc: got %0d expected 0", pc_out); end
    checks++; if (imem_addr !== 5'd0) begin failures++; $display("FAIL reset_imem_addr: got %0d expected 0", imem_addr); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out: got %h expected 0000", out_data); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b expected 0", halted); end
  endtask

  task automatic load_prog_add();
    clear_rom();
    rom[0] = enc(3'd4, 5'd5);   // LOADI 5
    rom[1] = enc(3'd2, 5'd31);  // ADD switches
    rom[2] = enc(3'd1, 5'd30);  // STORE port 0
    rom[3] = enc(3'd7, 5'd0);   // HALT
  endtask

  task automatic test_free_run();
    load_prog_add();
    switches = 8'h03;
    reset_dut();
    cycles(11);
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL free_run_early_halt: got %b expected 0", halted); end
    cycles(1);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL free_run_halted: got %b expected 1", halted); end
    checks++; if (out_data[7:0] !== 8'h08) begin failures++; $display("FAIL free_run_out0: got %h expected 08", out_data[7:0]); end
    checks++; if (pc_out !== 5'd4) begin failures++; $display("FAIL free_run_pc: got %0d expected 4", pc_out); end
    cycles(20);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL free_run_halt_hold: got %b expected 1", halted); end
    checks++; if (out_data[7:0] !== 8'h08) begin failures++; $display("FAIL free_run_out_hold: got %h expected 08", out_data[7:0]); end
  endtask

  task automatic test_loop();
    clear_rom();
    rom[0] = enc(3'd4, 5'd1);   // LOADI 1
    rom[1] = enc(3'd1, 5'd1);   // STORE 1
    rom[2] = enc(3'd4, 5'd3);   // LOADI 3
    rom[3] = enc(3'd3, 5'd1);   // SUB 1
    rom[4] = enc(3'd5, 5'd3);   // BNE 3
    rom[5] = enc(3'd1, 5'd30);  // STORE port 0
    rom[6] = enc(3'd7, 5'd0);   // HALT
    reset_dut();
    cycles(32);
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL loop_early_halt: got %b expected 0", halted); end
    cycles(1);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL loop_halted: got %b expected 1", halted); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL loop_out: got %h expected 0000", out_data); end
    checks++; if (pc_out !== 5'd7) begin failures++; $display("FAIL loop_pc: got %0d expected 7", pc_out); end
  endtask

  task automatic test_underflow();
    clear_rom();
    rom[0] = enc(3'd4, 5'd0);   // LOADI 0
    rom[1] = enc(3'd1, 5'd1);   // STORE 1
    rom[2] = enc(3'd4, 5'd1);   // LOADI 1
    rom[3] = enc(3'd1, 5'd2);   // STORE 2
    rom[4] = enc(3'd0, 5'd1);   // LOAD 1
    rom[5] = enc(3'd3, 5'd2);   // SUB 2  -> 0xFF
    rom[6] = enc(3'd1, 5'd29);  // STORE port 1
    rom[7] = enc(3'd5, 5'd9);   // BNE 9 (taken, z = 0)
    rom[8] = enc(3'd7, 5'd0);   // HALT -> pc 9 if not taken
    rom[9] = enc(3'd7, 5'd0);   // HALT -> pc 10 if taken
    reset_dut();
    cycles(26);
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL underflow_early_halt: got %b expected 0", halted); end
    cycles(1);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL underflow_halted: got %b expected 1", halted); end
    checks++; if (out_data !== 16'hFF00) begin failures++; $display("FAIL underflow_out: got %h expected ff00", out_data); end
    checks++; if (pc_out !== 5'd10) begin failures++; $display("FAIL underflow_bne_taken: pc got %0d expected 10", pc_out); end
  endtask

  task automatic test_step();
    clear_rom();
    rom[0] = enc(3'd4, 5'd5);   // LOADI 5
    rom[1] = enc(3'd1, 5'd30);  // STORE port 0
    rom[2] = enc(3'd7, 5'd0);   // HALT
    step_mode = 1'b1;
    step = 1'b0;
    reset_dut();
    cycles(10);
    checks++; if (pc_out !== 5'd0) begin failures++; $display("FAIL step_idle_pc: got %0d expected 0", pc_out); end
    step = 1'b1;
    cycles(1);
    step = 1'b0;
    cycles(2);
    checks++; if (pc_out !== 5'd1) begin failures++; $display("FAIL step_one_pc: got %0d expected 1", pc_out); end
    cycles(10);
    checks++; if (pc_out !== 5'd1) begin failures++; $display("FAIL step_hold_pc: got %0d expected 1", pc_out); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL step_hold_out: got %h expected 0000", out_data); end
    step = 1'b1;
    cycles(3);
    checks++; if (out_data[7:0] !== 8'h05) begin failures++; $display("FAIL step_held_store: got %h expected 05", out_data[7:0]); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL step_held_early_halt: got %b expected 0", halted); end
    cycles(3);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL step_held_halted: got %b expected 1", halted); end
    step = 1'b0;
    step_mode = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    load_prog_add();
    reset_dut();
    cycles(8);
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL midrun_pre_store: got %h expected 0000", out_data); end
    n_reset = 1'b0;   // reset lands on the EXEC edge of STORE 30
    cycles(1);
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL midrun_store_blocked: got %h expected 0000", out_data); end
    checks++; if (pc_out !== 5'd0) begin failures++; $display("FAIL midrun_pc: got %0d expected 0", pc_out); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL midrun_halted: got %b expected 0", halted); end
    n_reset = 1'b1;
    cycles(11);
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL midrun_rerun_early: got %b expected 0", halted); end
    cycles(1);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL midrun_rerun_halted: got %b expected 1", halted); end
    checks++; if (out_data[7:0] !== 8'h08) begin failures++; $display("FAIL midrun_rerun_out: got %h expected 08", out_data[7:0]); end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_free_run();
    test_loop();
    test_underflow();
    test_step();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
